mem_arbiter_n: RTL and testbench
================================

Name: mem_arbiter_n

Overview:
- Parametrised byte-serial memory controller with N request channels (for example LSB, ICache, future DCache/prefetch).
- Arbitrates the channels onto one 8-bit RAM/IO port.
- Serialises multi-byte loads and stores, honours a pipelined read latency, and gates IO stores on io_buffer_full.
- Sits between the caches/LSB and the top-level memory port, replacing the fixed two-client controller.

Parameters:
- NUM_CH, 2: number of request channels. Channel 0 has the highest priority.
- ADDR_W, 32: address width.
- DATA_BYTES, 4: maximum bytes per access. Defines LEN_W = $clog2(DATA_BYTES)+1.
- READ_LAT, 1: cycles from mem_a being driven to mem_din being valid. Legal range 1..3.
- ARB_GAP, 3: idle cycles with a pending eligible request before a grant. 0 means grant on the first edge.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global ready. State advances only on edges where rdy=1.
- roll  in  1  pipeline flush.
- io_buffer_full  in  1  IO output buffer full.
- mem_din  in  8  RAM/IO read byte.
- mem_dout  out  8  write byte.
- mem_a  out  ADDR_W  byte address.
- mem_wr  out  1  1 = write.
- ch_req  in  NUM_CH  per-channel request, held until that channel's commit.
- ch_store  in  NUM_CH  1 = store, 0 = load.
- ch_addr  in  NUM_CH*ADDR_W  flattened addresses. Channel i occupies [i*ADDR_W +: ADDR_W].
- ch_len  in  NUM_CH*LEN_W  byte count. 0 is treated as DATA_BYTES.
- ch_wdata  in  NUM_CH*8*DATA_BYTES  store data, little-endian.
- ch_commit  out  NUM_CH  one-hot, one-cycle completion pulse.
- rdata  out  8*DATA_BYTES  load result, valid while ch_commit is set. Bytes at index len and above are zero.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - outputs mem_a, mem_wr, mem_dout, ch_commit and rdata are all 0;
  - state goes to IDLE, gap counter to 0, round-robin pointer to 0.
- Eligibility: a channel is eligible when ch_req=1 and not (ch_store=1, addr[17:16]==2'b11 and io_buffer_full=1). Ineligible channels are skipped; lower-priority eligible channels may win instead.
- IDLE:
  - with no eligible channel: mem_a=0, mem_wr=0, mem_dout=0, gap counter cleared;
  - otherwise the gap counter increments each edge;
  - on the edge where the counter equals ARB_GAP, the winner is selected and its addr, len, store flag and wdata are latched;
  - at that grant edge E0: mem_a=addr; mem_wr=store; mem_dout=wdata[7:0].
- WRITE:
  - at edge Ek (k = 1..len-1): mem_a=addr+k, mem_dout=byte k, mem_wr=1;
  - at edge E(len): the granted channel's ch_commit pulses; mem_wr=0, mem_a=0; return to IDLE.
- READ:
  - at edge Ek (k < len): mem_a=addr+k, with mem_wr=0;
  - byte k is captured from mem_din at edge E(k+READ_LAT);
  - the commit pulse and rdata are driven at edge E(len+READ_LAT-1)+1 = E(len+READ_LAT);
  - mem_a is 0 after the last address; return to IDLE.
- Commit: exactly one ch_commit bit is high, for exactly one cycle, per access. ch_req de-assertion mid-access is ignored.
- rdy=0:
  - all state, counters, mem_a and mem_dout hold;
  - mem_wr and ch_commit are driven 0;
  - an edge that would have produced a commit is deferred to the next rdy=1 edge.
- roll (takes priority over rdy):
  - a read in flight, or a gap count, is aborted to IDLE with no commit; mem_a=0, mem_wr=0;
  - a store in flight continues stepping and commits normally; stores are roll-immune.
- Back-to-back: after a commit, the next grant takes a fresh ARB_GAP count. The IO-full check is evaluated at the grant edge only.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. The search starts at the channel after the last granted one; the pointer updates at each grant.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins. There is no pointer register.

Test Plan:
- Basic store: NUM_CH=2, READ_LAT=1, ARB_GAP=3; ch0 store addr 0x100, len 4, data 0xAABBCCDD.
  - Required: writes DD, CC, BB, AA to 0x100..0x103 on consecutive cycles, starting 4 edges after req.
  - Required: ch_commit[0] pulses 4 edges after E0; mem_wr is 0 afterwards.
- Load with latency: READ_LAT=2, ch1 load addr 0x200, len 2, RAM bytes 0x34, 0x12.
  - Required: rdata=0x00001234 with ch_commit[1] at E4, exactly one cycle.
- Priority and IO gating: ch0 store to 0x30000 with io_buffer_full=1, ch1 load pending.
  - Required: ch1 granted first; ch0 granted once io_buffer_full drops.
- Roll: roll asserted at E2 of a 4-byte load → no commit, mem_a=0 next cycle. Roll at E2 of a 4-byte store → all 4 bytes written and ch_commit pulses.
- rdy stall: rdy=0 for 3 cycles mid-store → mem_a held, mem_wr=0 throughout; completion shifts by exactly 3 cycles; byte order unchanged.
- Arbitration with MEM_ARB_RR_EN: both channels requesting continuously → grants alternate 0,1,0,1. Without the macro → ch0 wins every time.

Source files
------------

// File: rtl/mem_arbiter_n_if.sv
// Request-channel bus between the memory clients (master) and mem_arbiter_n (slave).
// Per-channel fields are flattened: channel i occupies slice i of each vector.
interface mem_arbiter_n_if #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int LEN_W      = $clog2(DATA_BYTES) + 1
);
  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH-1:0]            ch_store;
  logic [NUM_CH*ADDR_W-1:0]     ch_addr;
  logic [NUM_CH*LEN_W-1:0]      ch_len;
  logic [NUM_CH*8*DATA_BYTES-1:0] ch_wdata;
  logic [NUM_CH-1:0]            ch_commit;
  logic [8*DATA_BYTES-1:0]      rdata;

  modport master (
    output ch_req, ch_store, ch_addr, ch_len, ch_wdata,
    input  ch_commit, rdata
  );

  modport slave (
    input  ch_req, ch_store, ch_addr, ch_len, ch_wdata,
    output ch_commit, rdata
  );
endinterface

// File: rtl/mem_arbiter_n.sv
// Byte-serial N-channel memory arbiter/controller onto a single 8-bit RAM/IO port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (channel 0 first).
module mem_arbiter_n #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_BYTES = 4,
  parameter int READ_LAT   = 1,
  parameter int ARB_GAP    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              roll,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  mem_arbiter_n_if.slave    bus
);
  localparam int LEN_W  = $clog2(DATA_BYTES) + 1;
  localparam int STEP_W = $clog2(DATA_BYTES + READ_LAT + 1) + 1;
  localparam int GAP_W  = (ARB_GAP < 1) ? 1 : $clog2(ARB_GAP + 1);
  localparam int CH_W   = (NUM_CH < 2) ? 1 : $clog2(NUM_CH);
  localparam logic [STEP_W-1:0] LAT_S = STEP_W'(READ_LAT);
  localparam logic [GAP_W-1:0]  GAP_S = GAP_W'(ARB_GAP);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t                    state_q, state_d;
  logic [GAP_W-1:0]          gap_q, gap_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [STEP_W-1:0]         len_q, len_d;
  logic [8*DATA_BYTES-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]         mem_a_q, mem_a_d;
  logic [7:0]                mem_dout_q, mem_dout_d;
  logic                      mem_wr_q, mem_wr_d;
  logic [NUM_CH-1:0]         commit_q, commit_d;
  logic [8*DATA_BYTES-1:0]   rdata_q, rdata_d;

  logic [NUM_CH-1:0]         elig;
  logic                      win_found;
  logic [CH_W-1:0]           win_idx;
  logic [ADDR_W-1:0]         win_addr;
  logic [LEN_W-1:0]          win_len_raw;
  logic [STEP_W-1:0]         win_len;
  logic                      win_store;
  logic [8*DATA_BYTES-1:0]   win_wdata;
  logic [STEP_W-1:0]         step_nx;
  logic [STEP_W-1:0]         cap_idx;
  logic                      cap_en;

`ifdef MEM_ARB_RR_EN
  logic [CH_W-1:0]           ptr_q, ptr_d;
  int                        cand;
`endif

  // Stores aimed at the IO window (addr[17:16]==2'b11) wait while the IO buffer is full.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = bus.ch_req[i] &
                ~(bus.ch_store[i] & (bus.ch_addr[i*ADDR_W+16 +: 2] == 2'b11) & io_buffer_full);
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef MEM_ARB_RR_EN
    cand = 0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = (int'(ptr_q) + off) % NUM_CH;
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(cand);
      end
    end
`else
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_found = 1'b1;
        win_idx   = CH_W'(i);
      end
    end
`endif
    win_addr    = bus.ch_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    win_len_raw = bus.ch_len[int'(win_idx)*LEN_W +: LEN_W];
    win_len     = (win_len_raw == '0) ? STEP_W'(DATA_BYTES) : STEP_W'(win_len_raw);
    win_store   = bus.ch_store[win_idx];
    win_wdata   = bus.ch_wdata[int'(win_idx)*8*DATA_BYTES +: 8*DATA_BYTES];
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    step_d     = step_q;
    ch_d       = ch_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    commit_d   = '0;
    rdata_d    = rdata_q;
`ifdef MEM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    step_nx    = step_q + 1'b1;
    cap_idx    = step_nx - LAT_S;
    cap_en     = (step_nx >= LAT_S) && (cap_idx < len_q);

    // Roll aborts everything except a store, which must complete to keep memory consistent.
    if (roll && (state_q != S_WRITE)) begin
      state_d    = S_IDLE;
      gap_d      = '0;
      mem_a_d    = '0;
      mem_dout_d = '0;
    end else if (rdy) begin
      case (state_q)
        S_IDLE: begin
          mem_a_d    = '0;
          mem_dout_d = '0;
          if (!win_found) begin
            gap_d = '0;
          end else if (gap_q == GAP_S) begin
            gap_d      = '0;
            ch_d       = win_idx;
            addr_d     = win_addr;
            len_d      = win_len;
            wdata_d    = win_wdata;
            step_d     = '0;
            rdata_d    = '0;
            mem_a_d    = win_addr;
            mem_wr_d   = win_store;
            mem_dout_d = win_wdata[7:0];
            state_d    = win_store ? S_WRITE : S_READ;
`ifdef MEM_ARB_RR_EN
            ptr_d      = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
`endif
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_WRITE: begin
          step_d = step_nx;
          if (step_nx == len_q) begin
            commit_d[ch_q] = 1'b1;
            mem_a_d        = '0;
            mem_dout_d     = '0;
            state_d        = S_IDLE;
          end else begin
            mem_a_d    = addr_q + ADDR_W'(step_nx);
            mem_dout_d = wdata_q[8*int'(step_nx) +: 8];
            mem_wr_d   = 1'b1;
          end
        end
        S_READ: begin
          step_d  = step_nx;
          mem_a_d = (step_nx < len_q) ? addr_q + ADDR_W'(step_nx) : '0;
          // Byte k returns READ_LAT edges after its address was presented.
          if (cap_en) begin
            rdata_d[8*int'(cap_idx) +: 8] = mem_din;
          end
          if (step_nx == len_q + LAT_S) begin
            commit_d[ch_q] = 1'b1;
            state_d        = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      step_q     <= '0;
      ch_q       <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      commit_q   <= '0;
      rdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      step_q     <= step_d;
      ch_q       <= ch_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      commit_q   <= commit_d;
      rdata_q    <= rdata_d;
`ifdef MEM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Access descriptor is only consumed after a grant, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    len_q   <= len_d;
    wdata_q <= wdata_d;
  end

  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = mem_wr_q;
  assign bus.ch_commit = commit_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Self-checking bench for mem_arbiter_n: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the port behaviour.
module tb_mem_arbiter_n;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DB  = 4;
  localparam int LAT = 2;
  localparam int GAP = 3;
  localparam int LW  = $clog2(DB) + 1;

  logic        clk = 1'b0;
  logic        rst_n, rdy, roll, io_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_arbiter_n_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_BYTES(DB)) bus ();

  mem_arbiter_n #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_BYTES(DB), .READ_LAT(LAT), .ARB_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .roll(roll), .io_buffer_full(io_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM environment: 4 KiB aliased, read data appears LAT ready-edges after the address.
  logic [7:0]  ram [0:4095];
  logic [31:0] a_hist [1:3];
  logic [31:0] rd_addr;
  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 37 + 11);
    end else begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      if (pre_we) ram[pre_a] <= pre_d;
    end
  end
  always @(posedge clk) begin
    if (rdy) begin
      a_hist[1] <= mem_a;
      a_hist[2] <= a_hist[1];
      a_hist[3] <= a_hist[2];
    end
  end
  always_comb rd_addr = (LAT == 1) ? mem_a : a_hist[LAT-1];
  assign mem_din = ram[rd_addr[11:0]];

  // Reference model: one access at a time, described by its edge count since the grant.
  logic          m_busy, m_store;
  int            m_gap, m_ptr, m_ch, m_len, m_e, win;
  logic [31:0]   m_addr, tmp_a;
  logic [31:0]   m_wdata;
  logic [31:0]   exp_a;
  logic          exp_wr;
  logic [7:0]    exp_dout;
  logic [NCH-1:0] exp_commit;
  logic [31:0]   exp_rd, m_rd;
  logic          exp_rd_chk;

  function automatic logic eligible(input int c);
    logic [31:0] a;
    a = bus.ch_addr[c*AW +: AW];
    return bus.ch_req[c] && !(bus.ch_store[c] && a[17:16] == 2'b11 && io_full);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_store = 1'b0; m_gap = 0; m_ptr = 0; m_ch = 0; m_len = 0; m_e = 0;
      exp_a = '0; exp_wr = 1'b0; exp_dout = '0; exp_commit = '0; exp_rd = '0; exp_rd_chk = 1'b0;
    end else begin
      exp_wr = 1'b0; exp_commit = '0; exp_rd_chk = 1'b0;
      if (roll && !(m_busy && m_store)) begin
        m_busy = 1'b0; m_gap = 0; exp_a = '0;
      end else if (rdy) begin
        if (!m_busy) begin
          exp_a = '0;
          win = -1;
          for (int off = 0; off < NCH; off++) begin
`ifdef MEM_ARB_RR_EN
            if (win < 0 && eligible((m_ptr + off) % NCH)) win = (m_ptr + off) % NCH;
`else
            if (win < 0 && eligible(off)) win = off;
`endif
          end
          if (win < 0) m_gap = 0;
          else if (m_gap == GAP) begin
            m_gap   = 0;
            m_busy  = 1'b1;
            m_e     = 0;
            m_ch    = win;
            m_ptr   = (win + 1) % NCH;
            m_store = bus.ch_store[win];
            m_addr  = bus.ch_addr[win*AW +: AW];
            m_len   = int'(bus.ch_len[win*LW +: LW]);
            if (m_len == 0) m_len = DB;
            m_wdata = bus.ch_wdata[win*8*DB +: 8*DB];
            m_rd = '0;
            for (int k = 0; k < m_len; k++) begin
              tmp_a = m_addr + 32'(k);
              m_rd[8*k +: 8] = ram[tmp_a[11:0]];
            end
            exp_a = m_addr; exp_wr = m_store; exp_dout = m_wdata[7:0];
          end else m_gap++;
        end else begin
          m_e++;
          if (m_store) begin
            if (m_e == m_len) begin
              exp_commit[m_ch] = 1'b1; exp_a = '0; m_busy = 1'b0;
            end else begin
              exp_a = m_addr + 32'(m_e); exp_dout = m_wdata[8*m_e +: 8]; exp_wr = 1'b1;
            end
          end else begin
            exp_a = (m_e < m_len) ? m_addr + 32'(m_e) : '0;
            if (m_e == m_len + LAT) begin
              exp_commit[m_ch] = 1'b1; exp_rd = m_rd; exp_rd_chk = 1'b1; m_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;
  logic [39:0] wlog [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Every cycle: advance to the falling edge and compare the port against the model.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      check("mem_a", 64'(mem_a), 64'(exp_a));
      check("mem_wr", 64'(mem_wr), 64'(exp_wr));
      check("ch_commit", 64'(bus.ch_commit), 64'(exp_commit));
      if (exp_wr) check("mem_dout", 64'(mem_dout), 64'(exp_dout));
      if (exp_rd_chk) check("rdata", 64'(bus.rdata), 64'(exp_rd));
      if (mem_wr) wlog.push_back({mem_a, mem_dout});
    end
  endtask

  task automatic set_req(input int c, input logic st, input logic [31:0] a,
                         input logic [LW-1:0] l, input logic [31:0] d);
    bus.ch_store[c] = st;
    bus.ch_addr[c*AW +: AW] = a;
    bus.ch_len[c*LW +: LW] = l;
    bus.ch_wdata[c*8*DB +: 8*DB] = d;
    bus.ch_req[c] = 1'b1;
  endtask

  task automatic clr_req(input int c);
    bus.ch_req[c] = 1'b0;
  endtask

  task automatic wait_commit(input int limit, output int cyc, output logic [NCH-1:0] vec,
                             output logic [31:0] rd);
    cyc = 0; vec = '0; rd = '0;
    while (cyc < limit && vec == '0) begin
      tick();
      cyc++;
      vec = bus.ch_commit;
      rd  = bus.rdata;
    end
    if (vec == '0) check("commit_timeout", 64'(0), 64'(1));
  endtask

  task automatic rand_req(input int c);
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(3) == 0) a[17:16] = 2'b11;
    if ($urandom_range(15) == 0) a = 32'hFFFF_FFFE;
    set_req(c, 1'($urandom_range(1)), a, LW'($urandom_range(4, 0)), $urandom);
  endtask

  int cyc;
  logic [NCH-1:0] vec;
  logic [31:0] rd;
  logic seen;
  logic [NCH-1:0] arb_exp [4];

  initial begin
    rst_n = 1'b0; rdy = 1'b1; roll = 1'b0; io_full = 1'b0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    bus.ch_req = '0; bus.ch_store = '0; bus.ch_addr = '0; bus.ch_len = '0; bus.ch_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_a", 64'(mem_a), 64'(0));
    check("rst_mem_wr", 64'(mem_wr), 64'(0));
    check("rst_mem_dout", 64'(mem_dout), 64'(0));
    check("rst_commit", 64'(bus.ch_commit), 64'(0));
    check("rst_rdata", 64'(bus.rdata), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic store: four bytes little-endian, commit four edges after the grant.
    wlog.delete();
    set_req(0, 1'b1, 32'h100, 3'd4, 32'hAABBCCDD);
    wait_commit(40, cyc, vec, rd);
    clr_req(0);
    check("st_commit_cyc", 64'(cyc), 64'(8));
    check("st_commit_vec", 64'(vec), 64'(2'b01));
    check("st_nwrites", 64'(wlog.size()), 64'(4));
    if (wlog.size() == 4) begin
      check("st_w0", 64'(wlog[0]), 64'({32'h100, 8'hDD}));
      check("st_w1", 64'(wlog[1]), 64'({32'h101, 8'hCC}));
      check("st_w2", 64'(wlog[2]), 64'({32'h102, 8'hBB}));
      check("st_w3", 64'(wlog[3]), 64'({32'h103, 8'hAA}));
    end
    tick();
    check("st_after_wr", 64'(mem_wr), 64'(0));
    check("st_after_commit", 64'(bus.ch_commit), 64'(0));
    tick();

    // Load with READ_LAT=2: two bytes, commit at E4.
    pre_we = 1'b1; pre_a = 12'h200; pre_d = 8'h34;
    tick();
    pre_a = 12'h201; pre_d = 8'h12;
    tick();
    pre_we = 1'b0;
    tick();
    set_req(1, 1'b0, 32'h200, 3'd2, 32'h0);
    wait_commit(40, cyc, vec, rd);
    clr_req(1);
    check("ld_commit_cyc", 64'(cyc), 64'(8));
    check("ld_commit_vec", 64'(vec), 64'(2'b10));
    check("ld_rdata", 64'(rd), 64'(32'h0000_1234));
    tick();
    check("ld_one_cycle", 64'(bus.ch_commit), 64'(0));
    tick();

    // Priority and IO gating: the blocked IO store lets channel 1 through first.
    io_full = 1'b1;
    set_req(0, 1'b1, 32'h0003_0000, 3'd1, 32'h5A);
    set_req(1, 1'b0, 32'h10, 3'd1, 32'h0);
    wait_commit(40, cyc, vec, rd);
    check("io_first_vec", 64'(vec), 64'(2'b10));
    clr_req(1);
    io_full = 1'b0;
    wait_commit(40, cyc, vec, rd);
    clr_req(0);
    check("io_second_vec", 64'(vec), 64'(2'b01));
    check("io_second_cyc", 64'(cyc), 64'(5));
    repeat (2) tick();

    // Roll during a load: aborted, port idles, no commit.
    set_req(0, 1'b0, 32'h40, 3'd4, 32'h0);
    repeat (5) tick();
    roll = 1'b1;
    clr_req(0);
    tick();
    roll = 1'b0;
    check("roll_ld_mem_a", 64'(mem_a), 64'(0));
    check("roll_ld_mem_wr", 64'(mem_wr), 64'(0));
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (bus.ch_commit != '0) seen = 1'b1;
    end
    check("roll_ld_no_commit", 64'(seen), 64'(0));

    // Roll during a store: store completes and commits.
    wlog.delete();
    set_req(0, 1'b1, 32'h500, 3'd4, 32'h11223344);
    repeat (5) tick();
    roll = 1'b1;
    tick();
    roll = 1'b0;
    wait_commit(20, cyc, vec, rd);
    clr_req(0);
    check("roll_st_cyc", 64'(cyc), 64'(2));
    check("roll_st_vec", 64'(vec), 64'(2'b01));
    check("roll_st_nwrites", 64'(wlog.size()), 64'(4));
    if (wlog.size() == 4) begin
      check("roll_st_w0", 64'(wlog[0]), 64'({32'h500, 8'h44}));
      check("roll_st_w3", 64'(wlog[3]), 64'({32'h503, 8'h11}));
    end
    repeat (2) tick();

    // rdy stall for three cycles mid-store.
    wlog.delete();
    set_req(0, 1'b1, 32'h300, 3'd0, 32'hA1B2C3D4);
    repeat (5) tick();
    rdy = 1'b0;
    repeat (3) begin
      tick();
      check("stall_mem_a", 64'(mem_a), 64'(32'h301));
      check("stall_mem_wr", 64'(mem_wr), 64'(0));
    end
    rdy = 1'b1;
    wait_commit(20, cyc, vec, rd);
    clr_req(0);
    check("stall_total_cyc", 64'(cyc + 8), 64'(11));
    check("stall_nwrites", 64'(wlog.size()), 64'(4));
    if (wlog.size() == 4) begin
      check("stall_w0", 64'(wlog[0]), 64'({32'h300, 8'hD4}));
      check("stall_w1", 64'(wlog[1]), 64'({32'h301, 8'hC3}));
      check("stall_w2", 64'(wlog[2]), 64'({32'h302, 8'hB2}));
      check("stall_w3", 64'(wlog[3]), 64'({32'h303, 8'hA1}));
    end
    repeat (2) tick();

    // Continuous requests on both channels.
`ifdef MEM_ARB_RR_EN
    arb_exp[0] = 2'b01; arb_exp[1] = 2'b10; arb_exp[2] = 2'b01; arb_exp[3] = 2'b10;
`else
    arb_exp[0] = 2'b01; arb_exp[1] = 2'b01; arb_exp[2] = 2'b01; arb_exp[3] = 2'b01;
`endif
    set_req(0, 1'b0, 32'h20, 3'd1, 32'h0);
    set_req(1, 1'b0, 32'h28, 3'd1, 32'h0);
    for (int n = 0; n < 4; n++) begin
      wait_commit(40, cyc, vec, rd);
      check("arb_order", 64'(vec), 64'(arb_exp[n]));
    end
    clr_req(0);
    clr_req(1);
    repeat (3) tick();

    // Randomized traffic with stalls, rolls and IO back-pressure.
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.ch_req[c] && bus.ch_commit[c]) clr_req(c);
        else if (!bus.ch_req[c] && $urandom_range(3) == 0) rand_req(c);
      end
      rdy  = ($urandom_range(9) != 0);
      roll = ($urandom_range(39) == 0);
      if ($urandom_range(7) == 0) io_full = ~io_full;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
